// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_pkg
//  Purpose  : Shared types and default constants for the fetch PC sequencer.
//             PC_SEQ_TRAP_EN adds the default trap vector.
//  Revision : 1.0
// ============================================================================
package pc_seq_pkg;

    localparam int unsigned DEF_WIDTH        = 32;
    localparam int unsigned DEF_STEP         = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
`ifdef PC_SEQ_TRAP_EN
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;
`endif

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALTED   = 2'd3
    } pc_seq_state_t;

    typedef enum logic [2:0] {
        RK_NONE   = 3'd0,
        RK_TRAP   = 3'd1,
        RK_HALT   = 3'd2,
        RK_JUMP   = 3'd3,
        RK_BRANCH = 3'd4
    } pc_redir_kind_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Fetch-side bundle: PC feedback, next PC and fetch valid/ready.
//  Revision : 1.0
// ============================================================================
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic             fetch_valid;
    logic             fetch_ready;

    // master: the sequencer; slave: PC counter plus instruction memory
    modport master (
        input  pc,
        input  fetch_ready,
        output pc_next,
        output fetch_valid
    );

    modport slave (
        output pc,
        output fetch_ready,
        input  pc_next,
        input  fetch_valid
    );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_arb
//  Purpose  : Priority encoder for PC redirect sources; emits kind and an
//             aligned target. PC_SEQ_TRAP_EN adds trap at top priority.
//  Revision : 1.0
// ============================================================================
module pc_redirect_arb
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      STEP        = DEF_STEP
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(DEF_TRAP_VECTOR)
`endif
) (
`ifdef PC_SEQ_TRAP_EN
    input  wire logic             trap_i,
`endif
    input  wire logic             halt_i,
    input  wire logic             jump_i,
    input  wire logic [WIDTH-1:0] jump_target_i,
    input  wire logic             branch_taken_i,
    input  wire logic [WIDTH-1:0] branch_target_i,
    output pc_redir_kind_t        kind_o,
    output logic      [WIDTH-1:0] target_o
);

    // Clears the low log2(STEP) bits so redirects always land on a fetch slot
    localparam logic [WIDTH-1:0] C_ALIGN_MASK = ~(WIDTH'(STEP - 1));

    always_comb begin
        kind_o   = RK_NONE;
        target_o = '0;
`ifdef PC_SEQ_TRAP_EN
        if (trap_i) begin
            kind_o   = RK_TRAP;
            target_o = TRAP_VECTOR;
        end else
`endif
        if (halt_i) begin
            kind_o = RK_HALT;
        end else if (jump_i) begin
            kind_o   = RK_JUMP;
            target_o = jump_target_i & C_ALIGN_MASK;
        end else if (branch_taken_i) begin
            kind_o   = RK_BRANCH;
            target_o = branch_target_i & C_ALIGN_MASK;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch-stage PC controller: holds, advances or redirects the PC
//             held in the external counter. Optional feature: PC_SEQ_TRAP_EN.
//  Revision : 1.0
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter int unsigned      STEP         = DEF_STEP
`ifdef PC_SEQ_TRAP_EN
    ,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEF_TRAP_VECTOR)
`endif
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pc_sequencer_if.master        fetch_if,
    input  wire logic             stall_i,
    input  wire logic             branch_taken_i,
    input  wire logic [WIDTH-1:0] branch_target_i,
    input  wire logic             jump_i,
    input  wire logic [WIDTH-1:0] jump_target_i,
    input  wire logic             halt_i,
`ifdef PC_SEQ_TRAP_EN
    input  wire logic             trap_req_i,
    output logic      [WIDTH-1:0] epc_o,
`endif
    output logic                  redirect_o,
    output logic                  halted_o
);

    pc_seq_state_t    state_q, state_d;
    logic             fetch_valid_q;
    logic             redirect_q;
    logic             halted_q;
    pc_redir_kind_t   w_kind;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_next;

    pc_redirect_arb #(
        .WIDTH           (WIDTH),
        .STEP            (STEP)
`ifdef PC_SEQ_TRAP_EN
        ,
        .TRAP_VECTOR     (TRAP_VECTOR)
`endif
    ) u_arb (
`ifdef PC_SEQ_TRAP_EN
        .trap_i          (trap_req_i),
`endif
        .halt_i          (halt_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .kind_o          (w_kind),
        .target_o        (w_target)
    );

    always_comb begin
        state_d   = state_q;
        w_pc_next = fetch_if.pc;
        case (state_q)
            ST_BOOT: begin
                state_d   = ST_RUN;
                w_pc_next = RESET_VECTOR;
            end
            ST_RUN: begin
                case (w_kind)
                    RK_NONE: begin
                        if (fetch_if.fetch_ready && !stall_i) begin
                            w_pc_next = fetch_if.pc + WIDTH'(STEP);
                        end
                    end
                    RK_HALT: state_d = ST_HALTED;
                    default: begin
                        state_d   = ST_REDIRECT;
                        w_pc_next = w_target;
                    end
                endcase
            end
            ST_REDIRECT: state_d = ST_RUN;
            ST_HALTED:   state_d = ST_HALTED;
            default:     state_d = ST_BOOT;
        endcase
        if (rst) begin
            state_d   = ST_BOOT;
            w_pc_next = RESET_VECTOR;
        end
    end

    // Status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= (state_d == ST_RUN);
            redirect_q    <= (state_d == ST_REDIRECT);
            halted_q      <= (state_d == ST_HALTED);
        end
    end

`ifdef PC_SEQ_TRAP_EN
    logic [WIDTH-1:0] epc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (state_q == ST_RUN && w_kind == RK_TRAP) begin
            epc_q <= fetch_if.pc;
        end
    end

    assign epc_o = rst ? '0 : epc_q;
`endif

    // rst masks the registered status immediately, not just after the next edge
    assign fetch_if.pc_next     = w_pc_next;
    assign fetch_if.fetch_valid = fetch_valid_q & ~rst;
    assign redirect_o           = redirect_q & ~rst;
    assign halted_o             = halted_q & ~rst;

endmodule
`default_nettype wire
